// File: rtl/sm_lane_stream_pkg.sv
// sm_lane_stream_pkg
// Shared definitions for the lane streaming block:
//   SM_LANES / SM_LANE_W : default lane count and lane width
//   SM_MODE_PAR / SER    : encodings of the mode input
//   state_t              : control states of the output stage
package sm_lane_stream_pkg;

  localparam int   SM_LANES    = 4;
  localparam int   SM_LANE_W   = 8;

  localparam logic SM_MODE_PAR = 1'b0;
  localparam logic SM_MODE_SER = 1'b1;

  // IDLE: nothing to present; PAR: one rotated word pending;
  // SER: streaming the captured word one lane per beat
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAR  = 2'd1,
    ST_SER  = 2'd2
  } state_t;

endpackage

// File: rtl/sm_lane_stream_rot.sv
// sm_lane_rot
// Combinational LANES-way lane rotator.
//   sel  : rotate amount (start lane)
//   din  : input word, lane j = din[j*LANE_W +: LANE_W]
//   dout : rotated word, lane k = din lane ((k + sel) mod LANES)
module sm_lane_rot #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int SEL_W  = $clog2(LANES)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [LANES*LANE_W-1:0] din,
  output logic [LANES*LANE_W-1:0] dout
);

  // Doubling the word turns the modular rotation into a plain
  // window select starting at lane sel.
  logic [2*LANES*LANE_W-1:0] dbl;

  assign dbl  = {din, din};
  assign dout = dbl[int'(sel)*LANE_W +: LANES*LANE_W];

endmodule

// File: rtl/sm_lane_stream.sv
// sm_lane_stream
// Captures one LANES x LANE_W BRAM port-B word and presents it behind a
// valid/ready handshake, either as a whole rotated word (parallel mode)
// or as LANES single-lane beats starting at the selected lane (serial).
//   clk, rst       : clock, asynchronous active-low reset
//   sm_en          : enable for accepting new words
//   mode, sel, din : word attributes, sampled on accept
//   in_valid/ready : input handshake
//   out_valid/ready: output handshake
//   dout           : rotated word or single-lane beat
//   lane_idx       : source lane of dout lane 0
//   last           : final beat of the current word
module sm_lane_stream
  import sm_lane_stream_pkg::*;
#(
  parameter int LANES  = SM_LANES,
  parameter int LANE_W = SM_LANE_W,
  parameter int SEL_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sm_en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] dout,
  output logic [SEL_W-1:0]        lane_idx,
  output logic                    last
);

  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(LANES - 1);

  state_t                  state_q, state_d;
  logic [LANES*LANE_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [SEL_W-1:0]        beat_q, beat_d;

  logic                    busy;
  logic                    lastBeat;
  logic                    accept;
  logic                    drainLast;
  logic [SEL_W-1:0]        rotAmt;
  logic [LANES*LANE_W-1:0] rotWord;

  assign busy     = (state_q != ST_IDLE);
  assign lastBeat = (state_q == ST_PAR) ||
                    ((state_q == ST_SER) && (beat_q == LAST_BEAT));

  // Gated by rst so nothing can be offered as accepted while held in reset.
  assign in_ready  = rst && sm_en && (!busy || (out_ready && lastBeat));
  assign accept    = in_valid && in_ready;
  assign drainLast = busy && out_ready && lastBeat;

  // beat_q stays 0 in parallel mode, so one adder serves both modes.
  assign rotAmt = sel_q + beat_q;

  sm_lane_rot #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .SEL_W  (SEL_W)
  ) u_rot (
    .sel  (rotAmt),
    .din  (word_q),
    .dout (rotWord)
  );

  // State and captured word; reset clears everything so out_valid
  // drops immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
    end
  end

  // Accept can only happen when idle or when the last beat drains this
  // cycle, so it takes priority and starts the new word at beat 0.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = (mode == SM_MODE_PAR) ? ST_PAR : ST_SER;
      word_d  = din;
      sel_d   = sel;
      beat_d  = '0;
    end else if (drainLast) begin
      state_d = ST_IDLE;
      word_d  = '0;
      sel_d   = '0;
      beat_d  = '0;
    end else if ((state_q == ST_SER) && out_ready) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // Outputs depend only on registered state, so they hold still under
  // backpressure and read as zero whenever nothing is valid.
  always_comb begin
    out_valid = 1'b0;
    dout      = '0;
    lane_idx  = '0;
    last      = 1'b0;
    case (state_q)
      ST_PAR: begin
        out_valid = 1'b1;
        dout      = rotWord;
        lane_idx  = sel_q;
        last      = 1'b1;
      end
      ST_SER: begin
        out_valid = 1'b1;
        dout      = {{((LANES-1)*LANE_W){1'b0}}, rotWord[LANE_W-1:0]};
        lane_idx  = rotAmt;
        last      = lastBeat;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sm_lane_stream.sv
// tb_sm_lane_stream
// Directed stimulus for sm_lane_stream (LANES = 4, LANE_W = 8). A queue of
// expected output beats is built from each accepted word and checked every
// cycle; literal expectations pin the key scenarios.
module tb_sm_lane_stream;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int SEL_W  = 2;
  localparam int W      = LANES * LANE_W;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             smEn     = 1'b0;
  logic             mode     = 1'b0;
  logic [SEL_W-1:0] sel      = '0;
  logic             inValid  = 1'b0;
  logic [W-1:0]     din      = '0;
  logic             outReady = 1'b0;
  logic             inReady;
  logic             outValid;
  logic [W-1:0]     dout;
  logic [SEL_W-1:0] laneIdx;
  logic             last;

  int passCount  = 0;
  int checkCount = 0;
  bit checkOn    = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } beat_t;

  beat_t expQ[$];

  always #5 clk = ~clk;

  sm_lane_stream #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sm_en     (smEn),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .din       (din),
    .out_valid (outValid),
    .out_ready (outReady),
    .dout      (dout),
    .lane_idx  (laneIdx),
    .last      (last)
  );

  // Output lane k takes input lane (k + s) mod LANES.
  function automatic logic [W-1:0] rotModel(input logic [W-1:0] d, input int s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*LANE_W +: LANE_W] = d[((k + s) % LANES)*LANE_W +: LANE_W];
    return r;
  endfunction

  // The block can take a word when nothing is pending or the only pending
  // beat leaves this cycle.
  function automatic bit modelReady();
    return rst && smEn && (expQ.size() == 0 || (outReady && expQ.size() == 1));
  endfunction

  task automatic pushWord(input logic [W-1:0] d, input int s, input bit m);
    beat_t b;
    if (!m) begin
      b.data = rotModel(d, s);
      b.idx  = s;
      b.last = 1'b1;
      expQ.push_back(b);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        b.idx  = (s + i) % LANES;
        b.data = '0;
        b.data[LANE_W-1:0] = d[b.idx*LANE_W +: LANE_W];
        b.last = (i == LANES - 1);
        expQ.push_back(b);
      end
    end
  endtask

  // Model advances on the same edges the design does.
  always @(posedge clk or negedge rst) begin
    bit acc;
    if (!rst) begin
      expQ.delete();
    end else begin
      acc = inValid && modelReady();
      if (expQ.size() > 0 && outReady) void'(expQ.pop_front());
      if (acc) pushWord(din, int'(sel), mode);
    end
  end

  task automatic compareVal(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, act, exp, $time);
  endtask

  // Every cycle, away from the active edge, compare against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      compareVal("model in_ready", W'(inReady), W'(modelReady()));
      if (expQ.size() > 0) begin
        compareVal("model out_valid", W'(outValid), W'(1));
        compareVal("model dout", dout, expQ[0].data);
        compareVal("model lane_idx", W'(laneIdx), W'(expQ[0].idx));
        compareVal("model last", W'(last), W'(expQ[0].last));
      end else begin
        compareVal("model out_valid", W'(outValid), W'(0));
        compareVal("model dout idle", dout, '0);
        compareVal("model lane_idx idle", W'(laneIdx), '0);
        compareVal("model last idle", W'(last), '0);
      end
    end
  end

  task automatic applyStimulus(input bit en, input bit v, input bit m,
                               input logic [SEL_W-1:0] s, input logic [W-1:0] d,
                               input bit ordy);
    @(posedge clk);
    #2;
    smEn     = en;
    inValid  = v;
    mode     = m;
    sel      = s;
    din      = d;
    outReady = ordy;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input bit expV, input logic [W-1:0] expD,
                             input int expIdx, input bit expLast, input bit expRdy);
    @(negedge clk);
    compareVal({name, " out_valid"}, W'(outValid), W'(expV));
    compareVal({name, " dout"}, dout, expD);
    compareVal({name, " lane_idx"}, W'(laneIdx), W'(expIdx));
    compareVal({name, " last"}, W'(last), W'(expLast));
    compareVal({name, " in_ready"}, W'(inReady), W'(expRdy));
  endtask

  initial begin
    // Reset held with a valid word offered: nothing may be ready.
    rst = 1'b0; smEn = 1'b1; inValid = 1'b1; din = 32'hDEADBEEF; outReady = 1'b1;
    checkOn = 1'b1;
    checkOutput("reset", 1'b0, '0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1; inValid = 1'b0; din = '0;
    checkOutput("postReset", 1'b0, '0, 0, 1'b0, 1'b1);

    // Parallel rotate by one lane.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 32'h44332211, 1'b1);
    checkOutput("parAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("parRot", 1'b1, 32'h11443322, 1, 1'b1, 1'b1);
    idleCycle();
    checkOutput("parDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Serial stream starting at lane 3, wrapping around.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 32'h44332211, 1'b1);
    checkOutput("serAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("serBeat0", 1'b1, 32'h00000044, 3, 1'b0, 1'b0);
    idleCycle();
    checkOutput("serBeat1", 1'b1, 32'h00000011, 0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("serBeat2", 1'b1, 32'h00000022, 1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("serBeat3", 1'b1, 32'h00000033, 2, 1'b1, 1'b1);
    idleCycle();
    checkOutput("serDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Backpressure: a competing word is offered while stalled.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'hAABBCCDD, 1'b0);
    checkOutput("bpAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h55555555, 1'b0);
      checkOutput("bpStall", 1'b1, 32'hCCDDAABB, 2, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b1);
    checkOutput("bpRelease", 1'b1, 32'hCCDDAABB, 2, 1'b1, 1'b1);
    idleCycle();
    checkOutput("bpDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Back-to-back parallel words with no bubbles.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h00000000, 1'b1);
    checkOutput("b2bAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h01010101, 1'b1);
    checkOutput("b2bWord0", 1'b1, 32'h00000000, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h02020202, 1'b1);
    checkOutput("b2bWord1", 1'b1, 32'h01010101, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h03030303, 1'b1);
    checkOutput("b2bWord2", 1'b1, 32'h02020202, 0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("b2bWord3", 1'b1, 32'h03030303, 0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("b2bDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Serial last beat drains while a parallel word is accepted.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h0D0C0B0A, 1'b1);
    checkOutput("chainAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("chainBeat0", 1'b1, 32'h0000000A, 0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("chainBeat1", 1'b1, 32'h0000000B, 1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("chainBeat2", 1'b1, 32'h0000000C, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 32'h12345678, 1'b1);
    checkOutput("chainBeat3", 1'b1, 32'h0000000D, 3, 1'b1, 1'b1);
    idleCycle();
    checkOutput("chainPar", 1'b1, 32'h34567812, 3, 1'b1, 1'b1);
    idleCycle();
    checkOutput("chainDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Disabled block ignores an offered word until re-enabled.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 1'b1);
    checkOutput("enLow0", 1'b0, '0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 1'b1);
    checkOutput("enLow1", 1'b0, '0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 1'b1);
    checkOutput("enHigh", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("enWord", 1'b1, 32'hDEADBEEF, 0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("enDone", 1'b0, '0, 0, 1'b0, 1'b1);

    // Reset in the middle of a serial stream.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h44332211, 1'b1);
    checkOutput("rstAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("rstBeat0", 1'b1, 32'h00000011, 0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rstBeat1", 1'b1, 32'h00000022, 1, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    compareVal("asyncRst out_valid", W'(outValid), '0);
    compareVal("asyncRst dout", dout, '0);
    compareVal("asyncRst last", W'(last), '0);
    compareVal("asyncRst in_ready", W'(inReady), '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    checkOutput("rstRelease", 1'b0, '0, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 32'h0D0C0B0A, 1'b1);
    checkOutput("rstNewAccept", 1'b0, '0, 0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("rstNewBeat0", 1'b1, 32'h0000000B, 1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rstNewBeat1", 1'b1, 32'h0000000C, 2, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rstNewBeat2", 1'b1, 32'h0000000D, 3, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rstNewBeat3", 1'b1, 32'h0000000A, 0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("rstNewDone", 1'b0, '0, 0, 1'b0, 1'b1);

    checkOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
